// File: rtl/probe_burst_generator_pkg.sv
// Shared audio-path definitions: burst FSM states, default probe shape and
// sample-grid constants agreed between the ranging controller and the speaker path.
package probe_burst_generator_pkg;

  localparam int unsigned AMP_W   = 16;
  localparam int unsigned IDX_W   = 12;
  localparam int unsigned PHASE_W = 8;
  localparam int unsigned GUARD_W = 16;
  localparam int unsigned ENV_W   = 32;

  localparam int unsigned SAMPLE_RATE_HZ = 24000;

  localparam logic signed [AMP_W-1:0] DEFAULT_PEAK       = 16'sd20000;
  localparam logic [AMP_W-1:0]        DEFAULT_DECAY_STEP = 16'd2000;
  localparam int unsigned             DEFAULT_BURST_LEN  = 8;
  localparam int unsigned             DEFAULT_HALF_PERIOD = 2;
  localparam int unsigned             DEFAULT_GUARD_LEN  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BURST = 2'd2,
    GUARD = 2'd3
  } burst_state_t;

endpackage

// File: rtl/probe_burst_generator_if.sv
// Trigger/strobe/sample bundle between the ranging controller and the burst generator.
interface probe_burst_generator_if;
  import probe_burst_generator_pkg::*;

  logic                    step_in;
  logic                    impulse_in;
  logic                    impulse_out;
  logic signed [AMP_W-1:0] amp_out;
  logic                    busy;

  modport master (
    output step_in,
    output impulse_in,
    input  impulse_out,
    input  amp_out,
    input  busy
  );

  modport slave (
    input  step_in,
    input  impulse_in,
    output impulse_out,
    output amp_out,
    output busy
  );
endinterface

// File: rtl/probe_burst_generator.sv
// Emits a decaying, alternating-polarity probe burst on the sample grid after a trigger,
// flagging the first sample with impulse_out so the listener can start its delay count.
module probe_burst_generator
  import probe_burst_generator_pkg::*;
#(
  parameter logic signed [AMP_W-1:0] PEAK        = DEFAULT_PEAK,
  parameter logic [AMP_W-1:0]        DECAY_STEP  = DEFAULT_DECAY_STEP,
  parameter int unsigned             BURST_LEN   = DEFAULT_BURST_LEN,
  parameter int unsigned             HALF_PERIOD = DEFAULT_HALF_PERIOD,
  parameter int unsigned             GUARD_LEN   = DEFAULT_GUARD_LEN
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  probe_burst_generator_if.slave  bus
);

  // Envelope magnitude PEAK - idx*DECAY_STEP, clamped at zero; wide enough never to wrap.
  function automatic logic [AMP_W-1:0] envelope_mag(input logic [IDX_W-1:0] idx);
    logic [ENV_W-1:0] peak_u;
    logic [ENV_W-1:0] drop;
    peak_u = {{(ENV_W-AMP_W){1'b0}}, PEAK};
    drop   = ENV_W'(idx) * ENV_W'(DECAY_STEP);
    if (drop >= peak_u) begin
      return '0;
    end
    return AMP_W'(peak_u - drop);
  endfunction

  burst_state_t            state_q,   state_d;
  logic [IDX_W-1:0]        idx_q,     idx_d;
  logic [PHASE_W-1:0]      phase_q,   phase_d;
  logic                    pol_q,     pol_d;
  logic [GUARD_W-1:0]      guard_q,   guard_d;
  logic signed [AMP_W-1:0] amp_q,     amp_d;
  logic                    impulse_q, impulse_d;
  logic                    busy_q,    busy_d;

  logic signed [AMP_W-1:0] mag_s;
  logic                    phase_wrap;
  logic [GUARD_W-1:0]      guard_inc;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    pol_d      = pol_q;
    guard_d    = guard_q;
    amp_d      = amp_q;
    impulse_d  = 1'b0;
    busy_d     = busy_q;
    mag_s      = $signed(envelope_mag(idx_q));
    phase_wrap = (phase_q == PHASE_W'(HALF_PERIOD - 1));
    guard_inc  = guard_q + GUARD_W'(1);

    unique case (state_q)
      IDLE: begin
        amp_d = '0;
        if (bus.impulse_in) begin
          state_d = ARMED;
          busy_d  = 1'b1;
          idx_d   = '0;
          phase_d = '0;
          pol_d   = 1'b0;
          guard_d = '0;
        end
      end

      ARMED: begin
        if (bus.step_in) begin
          state_d   = BURST;
          amp_d     = PEAK;
          impulse_d = 1'b1;
          idx_d     = IDX_W'(1);
          phase_d   = phase_wrap ? '0 : phase_q + PHASE_W'(1);
          pol_d     = phase_wrap ? ~pol_q : pol_q;
        end
      end

      BURST: begin
        if (bus.step_in) begin
          if (idx_q == IDX_W'(BURST_LEN)) begin
            state_d = GUARD;
            amp_d   = '0;
            guard_d = '0;
          end else begin
            amp_d   = pol_q ? -mag_s : mag_s;
            idx_d   = idx_q + IDX_W'(1);
            phase_d = phase_wrap ? '0 : phase_q + PHASE_W'(1);
            pol_d   = phase_wrap ? ~pol_q : pol_q;
          end
        end
      end

      GUARD: begin
        amp_d = '0;
        if (bus.step_in) begin
          // A zero-length guard still spends one strobe here before re-arming.
          if (32'(guard_inc) >= 32'(GUARD_LEN)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            guard_d = guard_inc;
          end
        end
      end

      default: begin
        state_d = IDLE;
        amp_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      phase_q   <= '0;
      pol_q     <= 1'b0;
      guard_q   <= '0;
      amp_q     <= '0;
      impulse_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      pol_q     <= pol_d;
      guard_q   <= guard_d;
      amp_q     <= amp_d;
      impulse_q <= impulse_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.amp_out     = amp_q;
  assign bus.impulse_out = impulse_q;
  assign bus.busy        = busy_q;

endmodule
